// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES           = 4;
    localparam logic [31:0] DEFAULT_RESET_PC      = 32'h0000_0064;
    localparam logic [31:0] DEFAULT_MEM_LAST_ADDR = 32'h0000_0100;
    localparam int unsigned QUEUE_DEPTH           = 2;
    localparam int unsigned PTR_W                 = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W                 = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Widened to 33 bits so pc near 2^32 cannot wrap past the limit.
    function automatic logic addr_bad(input logic [31:0] pc, input logic [31:0] last_addr);
        return (pc[1:0] != 2'b00) ||
               (({1'b0, pc} + 33'(INSTR_BYTES - 1)) > {1'b0, last_addr});
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instr} entries between fetch and decode.
// Supports simultaneous push/pop and a synchronous flush.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic             rd_en;
    fetch_entry_t     entry_view [QUEUE_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign rd_en = pop_i && (count_q != '0);
    assign wr_en = push_i && ((count_q < CNT_W'(QUEUE_DEPTH)) || rd_en);

    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
        fetch_entry_t entry_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                entry_q <= '0;
            end else if (wr_en && !flush_i && (wr_ptr_q == PTR_W'(gi))) begin
                entry_q <= push_data_i;
            end
        end

        assign entry_view[gi] = entry_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = entry_view[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, boot/fetch/fault control and redirect handling
// in front of a single-cycle instruction memory; words queue toward decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter logic [31:0] MEM_LAST_ADDR = DEFAULT_MEM_LAST_ADDR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_pc,
    input  logic [31:0] i_instr,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_ready,
    output logic        o_fault,
    output logic [31:0] o_fault_pc
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_pc_q, fault_pc_d;

    logic             q_valid;
    fetch_entry_t     q_head;
    logic [CNT_W-1:0] q_count;
    logic             pop;
    logic             slot_free;
    logic             bad;
    logic             push;
    logic             take_fault;

    assign pop        = q_valid && i_ready;
    assign slot_free  = (q_count < CNT_W'(QUEUE_DEPTH)) || pop;
    assign bad        = addr_bad(pc_q, MEM_LAST_ADDR);
    assign push       = (state_q == FETCH) && !bad && slot_free && !i_redirect;
    assign take_fault = (state_q == FETCH) && bad && slot_free && !i_redirect;

    fetch_queue u_queue (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .flush_i     (i_redirect),
        .push_i      (push),
        .push_data_i ('{pc: pc_q, instr: i_instr}),
        .pop_i       (pop),
        .valid_o     (q_valid),
        .head_o      (q_head),
        .count_o     (q_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // Redirect overrides every other transition, including out of BOOT.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (take_fault) state_d = FAULT;
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
        if (i_redirect) begin
            state_d = FETCH;
            pc_d    = i_redirect_pc;
            fault_d = 1'b0;
        end else if (push) begin
            pc_d = pc_q + 32'(INSTR_BYTES);
        end else if (take_fault) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
        end
    end

    always_comb begin
        o_pc       = pc_q;
        o_valid    = q_valid;
        o_instr    = q_valid ? q_head.instr : 32'h0;
        o_instr_pc = q_valid ? q_head.pc    : 32'h0;
        o_fault    = fault_q;
        o_fault_pc = fault_pc_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected {pc, instr} words are queued as
// scenarios are driven and compared whenever decode accepts a word.
module tb_instr_fetch;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] o_pc;
    logic [31:0] i_instr;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_ready;
    logic        o_fault;
    logic [31:0] o_fault_pc;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb_q [$];
    logic [63:0] sb_head;

    instr_fetch dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_pc          (o_pc),
        .i_instr       (i_instr),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .i_ready       (i_ready),
        .o_fault       (o_fault),
        .o_fault_pc    (o_fault_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] imem(input logic [31:0] addr);
        case (addr)
            32'h64:  return 32'h0040_2303;
            32'h68:  return 32'h0060_2423;
            32'h90:  return 32'h0012_8293;
            default: return {addr[23:0], 8'h13};
        endcase
    endfunction

    // Single-cycle combinational instruction memory.
    always_comb i_instr = imem(o_pc);

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic exp_word(input logic [31:0] pc);
        sb_q.push_back({pc, imem(pc)});
    endtask

    // Handshake completes on the following rising edge; redirect-cycle
    // transfers are discarded by decode and therefore not scored.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready && !i_redirect) begin
            if (sb_q.size() == 0) begin
                check_val("unexp_xfer", {o_instr_pc, o_instr}, 64'h0);
            end else begin
                sb_head = sb_q.pop_front();
                check_val("xfer", {o_instr_pc, o_instr}, sb_head);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n       = 1'b0;
        i_ready       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        tick();
        tick();
        check_val("rst_valid", 64'(o_valid), 64'h0);
        check_val("rst_instr", 64'(o_instr), 64'h0);
        check_val("rst_instr_pc", 64'(o_instr_pc), 64'h0);
        check_val("rst_fault", 64'(o_fault), 64'h0);
        check_val("rst_fault_pc", 64'(o_fault_pc), 64'h0);
        check_val("rst_pc", 64'(o_pc), 64'h64);

        // Boot with decode always ready
        i_rst_n = 1'b1;
        exp_word(32'h64); exp_word(32'h68); exp_word(32'h6C); exp_word(32'h70);
        tick();
        check_val("boot_pc0", 64'(o_pc), 64'h64);
        check_val("boot_novalid", 64'(o_valid), 64'h0);
        tick();
        check_val("boot_pc1", 64'(o_pc), 64'h68);
        check_val("boot_valid", 64'(o_valid), 64'h1);
        tick();
        check_val("boot_pc2", 64'(o_pc), 64'h6C);
        tick(); tick(); tick();
        check_val("boot_drain", 64'(sb_q.size()), 64'h0);

        // Asynchronous reset while streaming
        i_rst_n = 1'b0;
        #1;
        check_val("async_valid", 64'(o_valid), 64'h0);
        check_val("async_pc", 64'(o_pc), 64'h64);

        // Backpressure from boot
        i_ready = 1'b0;
        tick();
        i_rst_n = 1'b1;
        sb_q.delete();
        tick(); tick(); tick(); tick();
        check_val("bp_pc_hold", 64'(o_pc), 64'h6C);
        check_val("bp_valid", 64'(o_valid), 64'h1);
        check_val("bp_head_pc", 64'(o_instr_pc), 64'h64);
        exp_word(32'h64); exp_word(32'h68); exp_word(32'h6C);
        i_ready = 1'b1;
        tick(); tick(); tick();
        i_ready = 1'b0;
        check_val("bp_drain", 64'(sb_q.size()), 64'h0);
        tick();
        check_val("full_hold_pc", 64'(o_pc), 64'h78);
        check_val("full_head_pc", 64'(o_instr_pc), 64'h70);

        // Redirect on a full queue
        i_redirect = 1'b1; i_redirect_pc = 32'h90;
        tick();
        i_redirect = 1'b0;
        check_val("redir_flush", 64'(o_valid), 64'h0);
        check_val("redir_pc", 64'(o_pc), 64'h90);
        tick();
        check_val("redir_valid", 64'(o_valid), 64'h1);
        check_val("redir_instr", 64'(o_instr), 64'h0012_8293);
        check_val("redir_instr_pc", 64'(o_instr_pc), 64'h90);

        // Redirect coinciding with push and pop
        exp_word(32'h90);
        i_ready = 1'b1;
        tick();
        i_redirect = 1'b1; i_redirect_pc = 32'h90;
        tick();
        i_redirect = 1'b0;
        check_val("rpp_flush", 64'(o_valid), 64'h0);
        check_val("rpp_pc", 64'(o_pc), 64'h90);
        check_val("rpp_drain", 64'(sb_q.size()), 64'h0);
        exp_word(32'h90); exp_word(32'h94); exp_word(32'h98);
        tick(); tick(); tick(); tick();
        check_val("rpp_stream", 64'(sb_q.size()), 64'h0);

        // Misaligned redirect target
        i_redirect = 1'b1; i_redirect_pc = 32'h92;
        tick();
        i_redirect = 1'b0;
        check_val("mis_nofault_yet", 64'(o_fault), 64'h0);
        tick();
        check_val("mis_fault", 64'(o_fault), 64'h1);
        check_val("mis_fault_pc", 64'(o_fault_pc), 64'h92);
        check_val("mis_novalid", 64'(o_valid), 64'h0);
        tick();
        check_val("mis_pc_hold", 64'(o_pc), 64'h92);
        check_val("mis_fault_hold", 64'(o_fault), 64'h1);
        i_redirect = 1'b1; i_redirect_pc = 32'h64;
        tick();
        i_redirect = 1'b0;
        check_val("clr_fault", 64'(o_fault), 64'h0);
        check_val("clr_fault_pc", 64'(o_fault_pc), 64'h92);
        check_val("clr_pc", 64'(o_pc), 64'h64);
        exp_word(32'h64);
        tick();
        tick();
        i_redirect = 1'b1; i_redirect_pc = 32'hFC;
        check_val("clr_resume", 64'(sb_q.size()), 64'h0);

        // Upper edge of the memory range
        tick();
        i_redirect = 1'b0;
        check_val("edge_pc", 64'(o_pc), 64'hFC);
        exp_word(32'hFC);
        tick();
        check_val("edge_next_pc", 64'(o_pc), 64'h100);
        check_val("edge_nofault", 64'(o_fault), 64'h0);
        tick();
        check_val("range_fault", 64'(o_fault), 64'h1);
        check_val("range_fault_pc", 64'(o_fault_pc), 64'h100);
        check_val("range_novalid", 64'(o_valid), 64'h0);
        tick();
        check_val("range_hold", 64'(o_fault), 64'h1);
        check_val("range_drain", 64'(sb_q.size()), 64'h0);

        // Reset while faulted
        i_rst_n = 1'b0;
        #2;
        check_val("frst_valid", 64'(o_valid), 64'h0);
        check_val("frst_instr", 64'(o_instr), 64'h0);
        check_val("frst_instr_pc", 64'(o_instr_pc), 64'h0);
        check_val("frst_fault", 64'(o_fault), 64'h0);
        check_val("frst_fault_pc", 64'(o_fault_pc), 64'h0);
        check_val("frst_pc", 64'(o_pc), 64'h64);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
